neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Sequential multiply-accumulate neuron for the XOR network datapath.
- Per operation: accepts a bias, then N_INPUTS (activation, weight) pairs over a valid/ready handshake, and accumulates the signed products.
- Presents the 33-bit sign-magnitude sum (bit 32 = sign, bits 31:0 = magnitude), held until consumed.
- Sits directly upstream of the squish compression stage, which takes this 33-bit word and reduces it to the 17-bit activation format.

Parameters:
- N_INPUTS, 2, number of (x, w) pairs per operation; legal range 1..255.
- DATA_W, 16, magnitude width of operands; operand word is DATA_W+1 bits, output word is 2*DATA_W+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- bias  in  17  sign-magnitude bias (bit16 sign, 15:0 magnitude); captured on accepted start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operand pair.
- x_in  in  17  sign-magnitude activation.
- w_in  in  17  sign-magnitude weight.
- out_valid  out  1  out_sum holds a completed result.
- out_ready  in  1  downstream consumes result.
- out_sum  out  33  sign-magnitude result (bit32 sign, 31:0 magnitude).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. All of in_ready, out_valid, out_sum, busy = 0. Internal accumulator = 0, beat counter = 0.
- Reset mid-operation: any partial sum is discarded; no output is produced for the aborted operation.
- Number format:
  - Sign-magnitude; -0 is treated as 0.
  - Product magnitude = x[15:0]*w[15:0], 32 bits unsigned.
  - Product sign = x[16]^w[16].
- Accumulator: internal two's complement, ACC_W = 2*DATA_W+9 bits (no overflow possible for N_INPUTS ≤ 255).
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready = 0.
  - On start=1: acc <= sign-extended bias, cnt <= 0, go to ACCUM.
- ACCUM:
  - in_ready = 1 (registered, asserted the cycle after start).
  - Beat = in_valid & in_ready. On each beat: acc += signed product, cnt += 1.
  - in_valid gaps are allowed; acc and cnt are held while no beat occurs.
  - On the beat where cnt == N_INPUTS-1: go to HOLD, in_ready drops next cycle.
  - out_sum is registered from the final acc (including that beat's product) and out_valid = 1 from the next cycle. Latency from last accepted beat to out_valid is 1 cycle.
  - start is ignored in ACCUM.
- Output conversion (registered):
  - sign = acc < 0; magnitude = |acc|.
  - If magnitude > 2^32-1, saturate magnitude to 32'hFFFF_FFFF; the sign is preserved.
  - If magnitude == 0, sign is forced to 0.
- HOLD:
  - out_valid = 1 and out_sum stable while out_ready = 0.
  - in_ready = 0; start and in_valid are ignored.
  - On out_ready=1: out_valid <= 0, go to IDLE. out_sum retains its last value.
  - A new start is accepted at the earliest in the cycle after the return to IDLE.
- No combinational path from any input to any output.

Test Plan:
1. Mixed signs: bias=+1; pairs (+3,+5), (+2,-4) -> out_valid 1 cycle after 2nd beat; out_sum = 33'h0_0000_0008.
2. Negative result: bias=-10; pairs (+3,-2), (-0,+7) -> out_sum = 33'h1_0000_0010.
3. Saturation: bias=+0; pairs (16'hFFFF,16'hFFFF) ×2 -> sum 0x1_FFFC_0002 -> out_sum = 33'h0_FFFF_FFFF. Repeat with one negative weight -> 33'h1_FFFF_FFFF.
4. Zero / -0: bias=-0; pairs (-0,+5), (+0,-9) -> out_sum = 33'h0_0000_0000 (sign bit 0).
5. Backpressure: in_valid toggled with 3-cycle gaps; out_ready held 0 for 5 cycles with start pulsed -> out_sum stable, in_ready 0, start ignored. out_ready=1 -> out_valid 0 next cycle, busy 0.
6. Reset mid-ACCUM: rst_n low after the first beat -> all outputs 0 immediately. A new operation from test 1 then yields 33'h0_0000_0008 with no residue.

Source files
------------

// File: rtl/neuron_mac.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neuron_mac : sequential sign-magnitude multiply-accumulate neuron
//              (bias + N_INPUTS products -> 33-bit saturated sign-magnitude)
// Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
module neuron_mac #(
  parameter int N_INPUTS = 2,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W:0]   bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   x_in,
  input  logic [DATA_W:0]   w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DATA_W:0] out_sum,
  output logic              busy
);

  localparam int         ACC_W    = 2*DATA_W + 9;
  localparam int         PROD_W   = 2*DATA_W;
  localparam logic [7:0] LAST_CNT = 8'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state_q;
  logic [ACC_W-1:0]     acc_q;
  logic [7:0]           cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*DATA_W:0]    out_sum_q;
  logic                 busy_q;

  logic                 w_beat;
  logic [PROD_W-1:0]    w_prod_mag;
  logic [ACC_W-1:0]     w_prod_ext;
  logic [ACC_W-1:0]     w_prod_signed;
  logic [ACC_W-1:0]     w_bias_ext;
  logic [ACC_W-1:0]     w_bias_signed;
  logic [ACC_W-1:0]     w_acc_d;
  logic                 w_acc_neg;
  logic [ACC_W-1:0]     w_acc_abs;
  logic                 w_sat;
  logic [2*DATA_W:0]    w_sum_d;

  assign w_beat        = in_valid & in_ready_q;
  assign w_prod_mag    = {{DATA_W{1'b0}}, x_in[DATA_W-1:0]} * {{DATA_W{1'b0}}, w_in[DATA_W-1:0]};
  assign w_prod_ext    = {{(ACC_W-PROD_W){1'b0}}, w_prod_mag};
  assign w_prod_signed = (x_in[DATA_W] ^ w_in[DATA_W]) ? -w_prod_ext : w_prod_ext;
  assign w_bias_ext    = {{(ACC_W-DATA_W){1'b0}}, bias[DATA_W-1:0]};
  assign w_bias_signed = bias[DATA_W] ? -w_bias_ext : w_bias_ext;
  assign w_acc_d       = acc_q + w_prod_signed;

  // A negative accumulator is never zero, so -0 cannot reach the output.
  assign w_acc_neg = w_acc_d[ACC_W-1];
  assign w_acc_abs = w_acc_neg ? -w_acc_d : w_acc_d;
  assign w_sat     = |w_acc_abs[ACC_W-1:PROD_W];
  assign w_sum_d   = {w_acc_neg, w_sat ? {PROD_W{1'b1}} : w_acc_abs[PROD_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q      <= w_bias_signed;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            acc_q <= w_acc_d;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == LAST_CNT) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_sum_q   <= w_sum_d;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_neuron_mac : scoreboard bench for neuron_mac (N_INPUTS=2, DATA_W=16)
// Revision      : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_neuron_mac;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [16:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] x_in;
  logic [16:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_sum;
  logic        busy;

  int checks;
  int errors;
  logic [32:0] sb_q[$];

  neuron_mac #(.N_INPUTS(2), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result computed with wide signed integers.
  function automatic logic [32:0] model(input logic [16:0] b, input logic [16:0] x0,
                                        input logic [16:0] w0, input logic [16:0] x1,
                                        input logic [16:0] w1);
    longint acc;
    longint p;
    longint mag;
    logic [16:0] xs[2];
    logic [16:0] ws[2];
    logic [63:0] mag_u;
    xs[0] = x0; xs[1] = x1; ws[0] = w0; ws[1] = w1;
    acc = longint'({48'd0, b[15:0]});
    if (b[16]) acc = -acc;
    for (int i = 0; i < 2; i++) begin
      p = longint'({48'd0, xs[i][15:0]}) * longint'({48'd0, ws[i][15:0]});
      if (xs[i][16] ^ ws[i][16]) acc = acc - p;
      else acc = acc + p;
    end
    mag = (acc < 0) ? -acc : acc;
    mag_u = 64'(mag);
    if (mag_u > 64'h0000_0000_FFFF_FFFF) mag_u = 64'h0000_0000_FFFF_FFFF;
    return {(acc < 0), mag_u[31:0]};
  endfunction

  task automatic run_op(input string name, input logic [16:0] b,
                        input logic [16:0] x0, input logic [16:0] w0,
                        input logic [16:0] x1, input logic [16:0] w1,
                        input int gap, input int hold);
    logic [16:0] xs[2];
    logic [16:0] ws[2];
    logic [32:0] exp_sum;
    xs[0] = x0; xs[1] = x1; ws[0] = w0; ws[1] = w1;
    sb_q.push_back(model(b, x0, w0, x1, w1));
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s gap_out_valid got %b want 0", name, out_valid);
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready_beat%0d got %b want 1", name, i, in_ready);
      end
      in_valid = 1'b1;
      x_in     = xs[i];
      w_in     = ws[i];
      @(negedge clk);
      in_valid = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out_valid_latency got %b want 1", name, out_valid);
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty got 0 want 1 entry", name);
      exp_sum = '0;
    end else begin
      exp_sum = sb_q.pop_front();
    end
    for (int h = 0; h < hold; h++) begin
      start    = (h == 1);
      bias     = 17'h0_1234;
      in_valid = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_sum !== exp_sum || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s hold%0d got sum=%h rdy=%b vld=%b want sum=%h rdy=0 vld=1",
                 name, h, out_sum, in_ready, out_valid, exp_sum);
      end
    end
    checks++;
    if (out_sum !== exp_sum) begin
      errors++;
      $display("FAIL %s out_sum got %h want %h", name, out_sum, exp_sum);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== exp_sum) begin
      errors++;
      $display("FAIL %s release got vld=%b busy=%b sum=%h want vld=0 busy=0 sum=%h",
               name, out_valid, busy, out_sum, exp_sum);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_busy got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 33'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b sum=%h busy=%b want all 0",
               in_ready, out_valid, out_sum, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mixed();
    run_op("mixed", 17'h0_0001, 17'h0_0003, 17'h0_0005, 17'h0_0002, 17'h1_0004, 0, 0);
    checks++;
    if (out_sum !== 33'h0_0000_0008) begin
      errors++;
      $display("FAIL mixed_const got %h want %h", out_sum, 33'h0_0000_0008);
    end
  endtask

  task automatic test_negative();
    run_op("negative", 17'h1_000A, 17'h0_0003, 17'h1_0002, 17'h1_0000, 17'h0_0007, 0, 0);
    checks++;
    if (out_sum !== 33'h1_0000_0010) begin
      errors++;
      $display("FAIL negative_const got %h want %h", out_sum, 33'h1_0000_0010);
    end
  endtask

  task automatic test_saturation();
    run_op("sat_pos", 17'h0_0000, 17'h0_FFFF, 17'h0_FFFF, 17'h0_FFFF, 17'h0_FFFF, 0, 0);
    checks++;
    if (out_sum !== 33'h0_FFFF_FFFF) begin
      errors++;
      $display("FAIL sat_pos_const got %h want %h", out_sum, 33'h0_FFFF_FFFF);
    end
    run_op("sat_neg", 17'h0_0000, 17'h0_FFFF, 17'h1_FFFF, 17'h0_FFFF, 17'h1_FFFF, 0, 0);
    checks++;
    if (out_sum !== 33'h1_FFFF_FFFF) begin
      errors++;
      $display("FAIL sat_neg_const got %h want %h", out_sum, 33'h1_FFFF_FFFF);
    end
  endtask

  task automatic test_zero();
    run_op("zero", 17'h1_0000, 17'h1_0000, 17'h0_0005, 17'h0_0000, 17'h1_0009, 0, 0);
    checks++;
    if (out_sum !== 33'h0_0000_0000) begin
      errors++;
      $display("FAIL zero_const got %h want %h", out_sum, 33'h0_0000_0000);
    end
    run_op("cancel", 17'h0_0006, 17'h1_0002, 17'h0_0003, 17'h0_0000, 17'h0_0001, 0, 0);
  endtask

  task automatic test_backpressure();
    run_op("backpressure", 17'h0_0064, 17'h0_0123, 17'h1_0045, 17'h1_0011, 17'h1_0022, 3, 5);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    bias  = 17'h0_0001;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    x_in     = 17'h0_0003;
    w_in     = 17'h0_0005;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 33'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b sum=%h busy=%b want all 0",
               in_ready, out_valid, out_sum, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 17'h0_0001, 17'h0_0003, 17'h0_0005, 17'h0_0002, 17'h1_0004, 0, 0);
    checks++;
    if (out_sum !== 33'h0_0000_0008) begin
      errors++;
      $display("FAIL after_reset_const got %h want %h", out_sum, 33'h0_0000_0008);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      run_op("random", 17'($urandom), 17'($urandom), 17'($urandom),
             17'($urandom), 17'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    x_in      = '0;
    w_in      = '0;
    out_ready = 1'b0;
    test_reset();
    test_mixed();
    test_negative();
    test_saturation();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
